// File: rtl/pwm_l2_pkg.sv
// Shared constants and types for the pwm_l2 three-phase PWM modulator.
package pwm_l2_pkg;

    localparam logic PWM_EDGE   = 1'b0;
    localparam logic PWM_CENTER = 1'b1;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_l2_deadtime.sv
// One phase leg: tracks the raw compare result and inserts a deadtime gap
// before driving the complementary gate pair.
module pwm_l2_deadtime
    import pwm_l2_pkg::*;
#(
    parameter int DEADTIME_WIDTH = 8
) (
    input  logic                      aclk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      tick,
    input  logic                      raw_in,
    input  logic [DEADTIME_WIDTH-1:0] deadtime,
    output logic                      pwm_h,
    output logic                      pwm_l
);

    localparam logic [DEADTIME_WIDTH-1:0] DT_ZERO = {DEADTIME_WIDTH{1'b0}};
    localparam logic [DEADTIME_WIDTH-1:0] DT_ONE  = {{(DEADTIME_WIDTH-1){1'b0}}, 1'b1};

    logic                      raw_r;
    logic                      raw_nxt_s;
    logic [DEADTIME_WIDTH-1:0] dt_r;
    logic [DEADTIME_WIDTH-1:0] dt_nxt_s;
    logic                      h_r;
    logic                      h_nxt_s;
    logic                      l_r;
    logic                      l_nxt_s;

    // Next-state logic: a raw edge (re)starts the gap, gates follow raw once dt expires.
    always_comb begin
        raw_nxt_s = raw_r;
        dt_nxt_s  = dt_r;
        h_nxt_s   = h_r;
        l_nxt_s   = l_r;
        if (!enable) begin
            raw_nxt_s = 1'b0;
            dt_nxt_s  = DT_ZERO;
            h_nxt_s   = 1'b0;
            l_nxt_s   = 1'b0;
        end else if (tick) begin
            if (raw_in != raw_r) begin
                raw_nxt_s = raw_in;
                if (deadtime == DT_ZERO) begin
                    dt_nxt_s = DT_ZERO;
                    h_nxt_s  = raw_in;
                    l_nxt_s  = ~raw_in;
                end else begin
                    dt_nxt_s = deadtime;
                    h_nxt_s  = 1'b0;
                    l_nxt_s  = 1'b0;
                end
            end else if (dt_r != DT_ZERO) begin
                dt_nxt_s = dt_r - DT_ONE;
                if (dt_r == DT_ONE) begin
                    h_nxt_s = raw_r;
                    l_nxt_s = ~raw_r;
                end else begin
                    h_nxt_s = 1'b0;
                    l_nxt_s = 1'b0;
                end
            end else begin
                h_nxt_s = raw_r;
                l_nxt_s = ~raw_r;
            end
        end else begin
            raw_nxt_s = raw_r;
        end
    end

    // Channel state registers.
    always_ff @(posedge aclk) begin
        if (reset) begin
            raw_r <= 1'b0;
            dt_r  <= DT_ZERO;
            h_r   <= 1'b0;
            l_r   <= 1'b0;
        end else begin
            raw_r <= raw_nxt_s;
            dt_r  <= dt_nxt_s;
            h_r   <= h_nxt_s;
            l_r   <= l_nxt_s;
        end
    end

    assign pwm_h = h_r;
    assign pwm_l = l_r;

endmodule

// File: rtl/pwm_l2.sv
// Multi-channel PWM modulator: shared edge/center carrier with period-start
// shadowing, per-channel compare and deadtime-protected gate pairs.
module pwm_l2
    import pwm_l2_pkg::*;
#(
    parameter int CHANNELS       = 3,
    parameter int COUNTER_WIDTH  = 32,
    parameter int DEADTIME_WIDTH = 8
) (
    input  logic                              aclk,
    input  logic                              reset,
    input  logic                              ce,
    input  logic                              enable,
    input  logic                              mode,
    input  logic [COUNTER_WIDTH-1:0]          period,
    input  logic [CHANNELS*COUNTER_WIDTH-1:0] comparator,
    input  logic [DEADTIME_WIDTH-1:0]         deadtime,
    output logic [CHANNELS-1:0]               pwm_h,
    output logic [CHANNELS-1:0]               pwm_l,
    output logic                              sync
);

    localparam logic [COUNTER_WIDTH-1:0] ZERO = {COUNTER_WIDTH{1'b0}};
    localparam logic [COUNTER_WIDTH-1:0] ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    logic [COUNTER_WIDTH-1:0]          cnt_r;
    logic [COUNTER_WIDTH-1:0]          cnt_nxt_s;
    dir_e                              dir_r;
    dir_e                              dir_nxt_s;
    logic                              mode_r;
    logic [COUNTER_WIDTH-1:0]          period_r;
    logic [CHANNELS*COUNTER_WIDTH-1:0] cmp_r;
    logic                              sync_r;

    logic                              tick_s;
    logic                              start_s;
    logic                              eff_mode_s;
    logic [COUNTER_WIDTH-1:0]          eff_period_s;
    logic [COUNTER_WIDTH-1:0]          last_s;
    logic [CHANNELS*COUNTER_WIDTH-1:0] eff_cmp_s;
    logic [CHANNELS-1:0]               raw_s;

    assign tick_s  = ce & enable;
    assign start_s = (cnt_r == ZERO) && (dir_r == UP);

    // The period-start tick already runs on the freshly loaded values.
    assign eff_mode_s   = start_s ? mode       : mode_r;
    assign eff_period_s = start_s ? period     : period_r;
    assign eff_cmp_s    = start_s ? comparator : cmp_r;
    assign last_s       = eff_period_s - ONE;

    // Carrier next-state: edge wraps, center bounces holding each end twice.
    always_comb begin
        cnt_nxt_s = cnt_r;
        dir_nxt_s = dir_r;
        if (eff_period_s == ZERO) begin
            cnt_nxt_s = ZERO;
            dir_nxt_s = UP;
        end else if (eff_mode_s == PWM_EDGE) begin
            dir_nxt_s = UP;
            if (cnt_r >= last_s) begin
                cnt_nxt_s = ZERO;
            end else begin
                cnt_nxt_s = cnt_r + ONE;
            end
        end else begin
            case (dir_r)
                UP: begin
                    if (cnt_r >= last_s) begin
                        dir_nxt_s = DOWN;
                    end else begin
                        cnt_nxt_s = cnt_r + ONE;
                    end
                end
                DOWN: begin
                    if (cnt_r == ZERO) begin
                        dir_nxt_s = UP;
                    end else begin
                        cnt_nxt_s = cnt_r - ONE;
                    end
                end
                default: begin
                    cnt_nxt_s = ZERO;
                    dir_nxt_s = UP;
                end
            endcase
        end
    end

    // Carrier, shadow and sync registers.
    always_ff @(posedge aclk) begin
        if (reset) begin
            cnt_r    <= ZERO;
            dir_r    <= UP;
            mode_r   <= PWM_EDGE;
            period_r <= ZERO;
            cmp_r    <= {(CHANNELS*COUNTER_WIDTH){1'b0}};
            sync_r   <= 1'b0;
        end else if (!enable) begin
            cnt_r    <= ZERO;
            dir_r    <= UP;
            mode_r   <= mode;
            period_r <= period;
            cmp_r    <= comparator;
            sync_r   <= 1'b0;
        end else if (tick_s) begin
            cnt_r  <= cnt_nxt_s;
            dir_r  <= dir_nxt_s;
            sync_r <= start_s;
            if (start_s) begin
                mode_r   <= mode;
                period_r <= period;
                cmp_r    <= comparator;
            end
        end else begin
            sync_r <= 1'b0;
        end
    end

    assign sync = sync_r;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [COUNTER_WIDTH-1:0] cmp_k_s;
        assign cmp_k_s  = eff_cmp_s[k*COUNTER_WIDTH +: COUNTER_WIDTH];
        assign raw_s[k] = (eff_period_s != ZERO) && (cnt_r < cmp_k_s);

        pwm_l2_deadtime #(
            .DEADTIME_WIDTH(DEADTIME_WIDTH)
        ) u_deadtime (
            .aclk    (aclk),
            .reset   (reset),
            .enable  (enable),
            .tick    (tick_s),
            .raw_in  (raw_s[k]),
            .deadtime(deadtime),
            .pwm_h   (pwm_h[k]),
            .pwm_l   (pwm_l[k])
        );
    end

endmodule
